// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit SRAM between the instruction and data ports.
// Optional performance counters are built only when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int ADDR_W    = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              i_req,
    input  logic [7:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [63:0]       i_rdata,

    input  logic              d_req,
    input  logic [7:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,

    output logic              mem_en,
    output logic [7:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,

    output logic              stallreq,
    output logic [63:0]       perf_conflict_cnt,
    output logic [63:0]       perf_i_wait_cnt,
    output logic [1:0]        owner_state
);

    // Handshake: a port raises req with we/addr/wdata and holds them stable
    // until it sees gnt in the same cycle; rvalid follows exactly one cycle
    // after gnt (read data or write acknowledge) and needs no ready.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    owner_t     owner_q;
    logic [3:0] burst_q;
    logic       burst_full;

    assign burst_full = (burst_q == BURST_LIM);

    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (!reset) begin
            d_gnt = d_req & ~(i_req & burst_full);
            i_gnt = i_req & ~d_gnt;
        end
    end

    always_comb begin
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_we    = i_we;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
        end
    end

    assign mem_en   = i_gnt | d_gnt;
    assign stallreq = ~reset & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

    // Owner tracks who gets the returning word; burst bounds instruction starvation.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            burst_q <= 4'd0;
        end else begin
            if (d_gnt)      owner_q <= OWN_DATA;
            else if (i_gnt) owner_q <= OWN_INST;
            else            owner_q <= OWN_NONE;

            if (!i_req || i_gnt)
                burst_q <= 4'd0;
            else if (d_gnt && !burst_full)
                burst_q <= burst_q + 4'd1;
        end
    end

    // Gating with reset drops a response that was in flight when reset arrived.
    assign i_rvalid    = ~reset & (owner_q == OWN_INST);
    assign d_rvalid    = ~reset & (owner_q == OWN_DATA);
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign owner_state = owner_q;

`ifdef MEM_ARB_PERF_EN
    logic [63:0] conflict_q;
    logic [63:0] i_wait_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= 64'd0;
            i_wait_q   <= 64'd0;
        end else begin
            if (i_req && d_req)  conflict_q <= conflict_q + 64'd1;
            if (i_req && !i_gnt) i_wait_q   <= i_wait_q + 64'd1;
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_i_wait_cnt   = i_wait_q;
`else
    assign perf_conflict_cnt = 64'd0;
    assign perf_i_wait_cnt   = 64'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-writable SRAM model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              i_req, d_req;
    logic [7:0]        i_we, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [63:0]       i_wdata, d_wdata;
    logic              i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [63:0]       i_rdata, d_rdata;
    logic              mem_en;
    logic [7:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              stallreq;
    logic [63:0]       perf_conflict_cnt, perf_i_wait_cnt;
    logic [1:0]        owner_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [63:0] WORD0 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] WORD1 = 64'hCAFE_F00D_8899_AABB;
    localparam logic [63:0] WDAT  = 64'h1122_3344_5566_7788;

    mem_port_arbiter #(.BURST_MAX(4), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stallreq(stallreq),
        .perf_conflict_cnt(perf_conflict_cnt),
        .perf_i_wait_cnt(perf_i_wait_cnt),
        .owner_state(owner_state)
    );

    always #5 clock = ~clock;

    // SRAM model: 16 words indexed by addr[6:3], read data one cycle after mem_en.
    logic [63:0] mem [16];
    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[6:3]];
            for (int b = 0; b < 8; b++)
                if (mem_we[b]) mem[mem_addr[6:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; i_we = 0; d_we = 0;
        i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0;
    endtask

    logic exp_d [10];

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 64'd0;
        mem[0] = WORD0;
        mem[1] = WORD1;
        mem_rdata = 64'd0;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // Reset state
        @(negedge clock);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_owner", owner_state, OWN_NONE);
        check("rst_perf_conf", perf_conflict_cnt, 0);

        // Instruction read only
        tick();
        i_req = 1; i_addr = 64'h8000_0000;
        @(negedge clock);
        check("ird_i_gnt", i_gnt, 1);
        check("ird_d_gnt", d_gnt, 0);
        check("ird_mem_en", mem_en, 1);
        check("ird_mem_addr", mem_addr, 64'h8000_0000);
        check("ird_stall", stallreq, 0);
        tick();
        i_req = 0;
        @(negedge clock);
        check("ird_i_rvalid", i_rvalid, 1);
        check("ird_i_rdata", i_rdata, WORD0);
        check("ird_d_rvalid", d_rvalid, 0);
        check("ird_idle_mem_en", mem_en, 0);
        check("ird_idle_mem_addr", mem_addr, 0);

        // Simultaneous requests: data first, instruction next cycle
        tick();
        i_req = 1; i_addr = 64'h8000_0000;
        d_req = 1; d_addr = 64'h8000_0008;
        @(negedge clock);
        check("sim_d_gnt", d_gnt, 1);
        check("sim_i_gnt", i_gnt, 0);
        check("sim_stall", stallreq, 1);
        check("sim_mem_addr", mem_addr, 64'h8000_0008);
        tick();
        d_req = 0;
        @(negedge clock);
        check("sim2_i_gnt", i_gnt, 1);
        check("sim2_d_rvalid", d_rvalid, 1);
        check("sim2_d_rdata", d_rdata, WORD1);
        check("sim2_stall", stallreq, 0);
        tick();
        i_req = 0;
        @(negedge clock);
        check("sim3_i_rvalid", i_rvalid, 1);
        check("sim3_i_rdata", i_rdata, WORD0);

        // Data write, then instruction read of the same word
        tick();
        d_req = 1; d_we = 8'hFF; d_addr = 64'h8000_0010; d_wdata = WDAT;
        @(negedge clock);
        check("wr_d_gnt", d_gnt, 1);
        check("wr_mem_we", mem_we, 8'hFF);
        check("wr_mem_wdata", mem_wdata, WDAT);
        tick();
        d_req = 0; d_we = 0; d_wdata = 0;
        i_req = 1; i_addr = 64'h8000_0010;
        @(negedge clock);
        check("wr_d_rvalid", d_rvalid, 1);
        check("wr_i_gnt", i_gnt, 1);
        check("wr_i_mem_we", mem_we, 8'h00);
        tick();
        i_req = 0;
        @(negedge clock);
        check("wr_rb_rvalid", i_rvalid, 1);
        check("wr_rb_rdata", i_rdata, WDAT);

        // Starvation bound, starting from a clean reset
        tick();
        reset = 1;
        tick();
        reset = 0;
        exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        i_req = 1; i_addr = 64'h8000_0000;
        d_req = 1; d_addr = 64'h8000_0008;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("burst_d_gnt_%0d", k), d_gnt, exp_d[k]);
            check($sformatf("burst_i_gnt_%0d", k), i_gnt, !exp_d[k]);
            tick();
        end
        idle_inputs();
        @(negedge clock);
`ifdef MEM_ARB_PERF_EN
        check("perf_conflict", perf_conflict_cnt, 64'd10);
        check("perf_i_wait", perf_i_wait_cnt, 64'd8);
`else
        check("perf_conflict_off", perf_conflict_cnt, 64'd0);
        check("perf_i_wait_off", perf_i_wait_cnt, 64'd0);
`endif

        // Reset arriving in the cycle after an instruction grant
        tick();
        i_req = 1; i_addr = 64'h8000_0000;
        @(negedge clock);
        check("rr_i_gnt", i_gnt, 1);
        tick();
        reset = 1; d_req = 1; d_addr = 64'h8000_0008;
        @(negedge clock);
        check("rr_i_rvalid", i_rvalid, 0);
        check("rr_i_gnt_rst", i_gnt, 0);
        check("rr_d_gnt_rst", d_gnt, 0);
        check("rr_mem_en_rst", mem_en, 0);
        check("rr_stall_rst", stallreq, 0);
        tick();
        @(negedge clock);
        check("rr_owner_in_rst", owner_state, OWN_NONE);
        check("rr_i_rvalid2", i_rvalid, 0);
        check("rr_d_gnt_rst2", d_gnt, 0);
        tick();
        reset = 0;
        idle_inputs();
        @(negedge clock);
        check("rr_owner_after", owner_state, OWN_NONE);
        check("rr_i_rvalid3", i_rvalid, 0);
        check("rr_perf_clear", perf_i_wait_cnt, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported 64-bit synchronous SRAM between the pipeline's instruction-fetch port and data-access port, so the core runs on a unified memory instead of two separate SRAMs. It sits between the core's inst/data SRAM interfaces and one memory instance. It grants at most one request per cycle and routes the one-cycle-late read data back to the granted requester. It also drives the core's `stallreq` input while any request is waiting.

## Interface
Parameters:
- `BURST_MAX`, default 4: maximum consecutive data grants while an instruction request waits. Legal range 1..15.
- `ADDR_W`, default 64: address width.

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `i_req` in 1: instruction port requests access.
- `i_we` in 8: byte write enables, one bit per byte; all zero means a read.
- `i_addr` in ADDR_W: instruction port address.
- `i_wdata` in 64: instruction port write data.
- `i_gnt` out 1: instruction request accepted this cycle.
- `i_rvalid` out 1: instruction response cycle.
- `i_rdata` out 64: instruction read data.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: same as the `i_*` set, for the data port.
- `mem_en` out 1: shared memory enable.
- `mem_we` out 8: shared memory byte write enables.
- `mem_addr` out ADDR_W: shared memory address.
- `mem_wdata` out 64: shared memory write data.
- `mem_rdata` in 64: shared memory read data, valid one cycle after `mem_en`.
- `stallreq` out 1: to the core; high while any request is not granted.
- `perf_conflict_cnt` out 64: cycles with both `i_req` and `d_req` high.
- `perf_i_wait_cnt` out 64: cycles with `i_req` high and `i_gnt` low.

## Operation
- **Grant logic** is combinational in the request cycle:
  - Only `d_req` high: `d_gnt`=1.
  - Only `i_req` high: `i_gnt`=1.
  - Both high: data wins, unless `burst_q == BURST_MAX`; then the instruction port wins.
  - `i_gnt` and `d_gnt` are never high in the same cycle.
- **Burst counter** `burst_q` is 4 bits:
  - Increments on a data grant while `i_req` is high; it saturates at `BURST_MAX`.
  - Clears on any instruction grant, and on any cycle with `i_req` low.
- **Memory mux:**
  - `mem_en = i_gnt | d_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` come from the granted port.
  - With no grant, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- **Owner register** `owner_q` takes one of NONE, INST or DATA:
  - It registers the grant target each cycle; NONE when there was no grant.
  - `i_rvalid = (owner_q == INST)` and `d_rvalid = (owner_q == DATA)`. rvalid pulses for reads and writes alike; for a write it is the acknowledge.
  - `i_rdata` and `d_rdata` both equal `mem_rdata`. Only the owner's rvalid qualifies the data.
- **Requester rules:** a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. It may issue a new request in the cycle after `gnt`; back-to-back grants are allowed.
- **Stall output:** `stallreq = (i_req & ~i_gnt) | (d_req & ~d_gnt)`.

## Timing
- Grant latency: same cycle as `req` when the port wins.
- Response latency: rvalid is exactly one cycle after `gnt`.
- Throughput: one access per cycle, sustained.
- Reset values, applied in the cycle after `reset` is sampled high:
  - `owner_q` = NONE.
  - `burst_q` = 0.
  - Perf counters = 0.
- Output values:
  - All rvalid = 0 after reset.
  - While `reset` is high, `i_gnt`, `d_gnt`, `mem_en` and `stallreq` are forced to 0.
- Reset during an outstanding read: the pending response is dropped and no rvalid is produced.
- Worst-case instruction wait under continuous data requests: `BURST_MAX` cycles.

## Configuration
- Controlled by the macro `MEM_ARB_PERF_EN`.
- **Defined:**
  - `perf_conflict_cnt` increments every cycle with `i_req & d_req`.
  - `perf_i_wait_cnt` increments every cycle with `i_req & ~i_gnt`.
  - Both counters are 64-bit and wrap modulo 2^64.
  - Both clear on `reset`.
- **Undefined:**
  - No counter flops are built; both outputs are constant 0.
  - Arbitration behaviour is identical with and without the macro.

## Test plan
- **Instruction read only:** `i_req`=1, `i_addr`=0x8000_0000, `i_we`=0.
  - Expect `i_gnt`=1 and `mem_en`=1 with `mem_addr`=0x8000_0000 in the same cycle.
  - Next cycle: `i_rvalid`=1 and `i_rdata` equals the memory word; `d_rvalid`=0.
- **Simultaneous requests:** `i_req`=`d_req`=1 for one cycle.
  - Expect `d_gnt`=1, `i_gnt`=0 and `stallreq`=1.
  - Next cycle, with `d_req`=0: `i_gnt`=1, `d_rvalid`=1 and `stallreq`=0.
- **Starvation bound:** `BURST_MAX`=4, `d_req` and `i_req` held at 1 for 10 cycles.
  - Grant sequence must be D,D,D,D,I,D,D,D,D,I.
- **Data write:** `d_we`=0xFF, `d_addr`=0x8000_0010, `d_wdata`=0x1122334455667788.
  - `mem_we`=0xFF; next cycle `d_rvalid`=1.
  - A following `i_req` read of the same address returns 0x1122334455667788.
- **Reset with read outstanding:** assert `reset` in the cycle after `i_gnt`.
  - `i_rvalid` stays 0.
  - All grants are 0 while `reset` is high.
  - `owner_q` is NONE after reset.
- **Perf counters:** with `MEM_ARB_PERF_EN` defined, run scenario 3 (starvation bound).
  - `perf_conflict_cnt`=10 and `perf_i_wait_cnt`=8.
  - With the macro undefined, both stay 0.
